matrix_scan_driver: RTL
=======================

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 Parameter COLS, default 64: columns per panel row, power of two, at least 2.
REQ-002 Parameter ROWS_HALF, default 16: scan rows per half-panel, power of two, at least 2.
REQ-003 Parameter ON_CYCLES, default 256: clk cycles m_oe_n is held low per row, at least 1.
REQ-004 Port clk, input, 1: single clock; all logic rises on clk.
REQ-005 Port rst, input, 1: synchronous, active-low reset; sampled on clk rising edge.
REQ-006 Port en, input, 1: scan enable.
REQ-007 Port pix_rd_col, output, log2(COLS): pixel column read address to the upstream matrix_generate store.
REQ-008 Port pix_rd_row, output, log2(ROWS_HALF): pixel row read address to the upstream store.
REQ-009 Port pix_data, input, 6: {R0,G0,B0,R1,G1,B1} for the addressed pixel, valid exactly 1 cycle after the address.
REQ-010 Ports r0, g0, b0, r1, g1, b1, output, 1 each: registered panel colour lines.
REQ-011 Port m_clk, output, 1: panel shift clock; the panel samples colour lines on its rising edge.
REQ-012 Port m_lat, output, 1: panel latch, active high.
REQ-013 Port m_oe_n, output, 1: panel output enable, active low.
REQ-014 Port m_addr, output, log2(ROWS_HALF): panel row select.
REQ-015 Port frame_done, output, 1: one-cycle pulse at frame end; drives the upstream shift input.

Function
REQ-016 FSM states: IDLE, SHIFT, BLANK, LATCH, DISPLAY; every output is registered.
REQ-017 IDLE: if en=1, go to SHIFT on the next cycle; otherwise stay.
REQ-018 SHIFT lasts exactly 2*COLS+2 cycles, indexed k=0..2*COLS+1; pix_rd_row = current row r.
REQ-019 For k<2*COLS, pix_rd_col = floor(k/2); otherwise pix_rd_col holds COLS-1.
REQ-020 Colour outputs load pix_data only at the end of odd k; they hold column c during k=2c+2 and k=2c+3.
REQ-021 m_clk is 1 only on odd k>=3: exactly COLS rising edges per row, column 0 first.
REQ-022 Colour outputs change only while m_clk=0.
REQ-023 BLANK lasts 1 cycle: m_oe_n=1, m_clk=0, m_addr<=r.
REQ-024 LATCH lasts 1 cycle: m_lat=1, m_oe_n=1; m_lat=0 in every other state.
REQ-025 DISPLAY lasts exactly ON_CYCLES cycles with m_oe_n=0; m_oe_n=1 in all other states.
REQ-026 At DISPLAY exit, r <= r+1, wrapping from ROWS_HALF-1 to 0.
REQ-027 frame_done=1 for the single cycle after DISPLAY of row ROWS_HALF-1 ends, then 0.
REQ-028 At DISPLAY exit, go to SHIFT if en=1, else to IDLE; r is retained in IDLE.
REQ-029 en is evaluated only in IDLE and at DISPLAY exit; en=0 mid-row completes the row, including its frame_done if it is the last row.
REQ-030 In IDLE: m_clk=0, m_lat=0, m_oe_n=1; colour outputs hold their last values.
REQ-031 Counters are sized so ON_CYCLES and 2*COLS+1 never overflow; no wrap occurs inside a state.

Reset
REQ-032 While rst=0 at a clk edge, the following SHALL load: state=IDLE, r=0, k=0, pix_rd_col=0, pix_rd_row=0, all colour outputs 0, m_clk=0, m_lat=0, m_oe_n=1, m_addr=0, frame_done=0.
REQ-033 Reset asserted in any state aborts it immediately; no partial latch or display pulse follows.

Structure
REQ-034 Shared package matrix_pkg holds the state enum, the pix_data bit-order constants, and the defaults for COLS and ROWS_HALF.
REQ-035 Sub-module matrix_shift_out implements the SHIFT-phase k counter, addressing and m_clk/colour timing; the FSM stays in matrix_scan_driver.

Verification
REQ-036 With COLS=4, ROWS_HALF=2, ON_CYCLES=3, raise en after reset: SHIFT lasts 10 cycles with m_clk=1 at k=3,5,7,9, then 1 BLANK, 1 LATCH and 3 DISPLAY cycles.
REQ-037 Model returns pix_data=column index pattern (6'b000001 << c): the bench captures 4 m_clk rises in order col0..col3 and all values match.
REQ-038 Run 2 rows: frame_done pulses once, for 1 cycle, after row 1 DISPLAY; m_addr sequence is 0, 1, 0.
REQ-039 Drop en during SHIFT of row 0: the row completes through DISPLAY, the FSM enters IDLE with m_oe_n=1, and r=1 is retained.
REQ-040 Assert rst=0 during DISPLAY: the next cycle shows m_oe_n=1, m_addr=0 and state IDLE, with no m_lat pulse.
REQ-041 Assertion: m_lat=1 implies m_oe_n=1, and colour outputs are never seen changing while m_clk=1.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix scan path: FSM states, pixel word
// bit order and the default panel geometry.
package matrix_pkg;

  localparam int DEF_COLS      = 64;
  localparam int DEF_ROWS_HALF = 16;

  // pix_data is {R0,G0,B0,R1,G1,B1}, upper half-panel first
  localparam int PIX_R0 = 5;
  localparam int PIX_G0 = 4;
  localparam int PIX_B0 = 3;
  localparam int PIX_R1 = 2;
  localparam int PIX_G1 = 1;
  localparam int PIX_B1 = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } scan_state_e;

endpackage

// File: rtl/matrix_scan_checker.sv
// Panel protocol properties: latching only while blanked, and colour lines
// stable whenever the shift clock is high.
module matrix_scan_checker (
  input logic       clk,
  input logic       rst,
  input logic       m_lat,
  input logic       m_oe_n,
  input logic       m_clk,
  input logic [5:0] colour
);

  a_lat_blanked: assert property (@(posedge clk) disable iff (!rst)
    m_lat |-> m_oe_n)
    else $error("m_lat high while output enabled");

  a_colour_stable: assert property (@(posedge clk) disable iff (!rst)
    (colour != $past(colour)) |-> !m_clk)
    else $error("colour lines moved while m_clk high");

endmodule

// File: rtl/matrix_shift_out.sv
// Shift phase of one panel row: k counter, pixel read addressing, shift clock
// and colour line timing. Colours are loaded while m_clk is low and held for
// the following rising edge.
module matrix_shift_out
  import matrix_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS_HALF = DEF_ROWS_HALF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(ROWS_HALF)-1:0] row,
  input  logic [5:0]                   pix_data,
  output logic [$clog2(COLS)-1:0]      pix_rd_col,
  output logic [$clog2(ROWS_HALF)-1:0] pix_rd_row,
  output logic [5:0]                   colour,
  output logic                         m_clk,
  output logic                         last
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS_HALF);
  localparam int K_W   = $clog2(2 * COLS + 2);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(2 * COLS + 1);
  localparam logic [K_W-1:0]   K_COLS2 = K_W'(2 * COLS);
  localparam logic [K_W-1:0]   K_FIRST_CLK = K_W'(3);
  localparam logic [COL_W-1:0] COL_MAX = {COL_W{1'b1}};

  logic             active_q, active_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [COL_W-1:0] pix_rd_col_q, pix_rd_col_d;
  logic [ROW_W-1:0] pix_rd_row_q, pix_rd_row_d;
  logic [5:0]       colour_q, colour_d;
  logic             m_clk_q, m_clk_d;

  // Next-state for the k counter and the registered shift outputs
  always_comb begin
    active_d     = active_q;
    k_d          = k_q;
    pix_rd_col_d = pix_rd_col_q;
    pix_rd_row_d = pix_rd_row_q;
    colour_d     = colour_q;
    m_clk_d      = 1'b0;

    if (start) begin
      active_d = 1'b1;
      k_d      = {K_W{1'b0}};
    end else if (active_q && (k_q == K_LAST)) begin
      active_d = 1'b0;
      k_d      = {K_W{1'b0}};
    end else if (active_q) begin
      k_d = k_q + K_W'(1);
    end else begin
      active_d = active_q;
    end

    // Outputs are registered, so they are derived from the upcoming k
    if (active_d) begin
      pix_rd_row_d = row;
      if (k_d < K_COLS2) begin
        pix_rd_col_d = k_d[COL_W:1];
      end else begin
        pix_rd_col_d = COL_MAX;
      end
      if (k_d[0] && (k_d >= K_FIRST_CLK)) begin
        m_clk_d = 1'b1;
      end else begin
        m_clk_d = 1'b0;
      end
    end else begin
      pix_rd_row_d = pix_rd_row_q;
      pix_rd_col_d = pix_rd_col_q;
    end

    // Data for the address of even k arrives during odd k
    if (active_q && k_q[0] && (k_q < K_COLS2)) begin
      colour_d = pix_data;
    end else begin
      colour_d = colour_q;
    end
  end

  // Shift-phase state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q     <= 1'b0;
      k_q          <= {K_W{1'b0}};
      pix_rd_col_q <= {COL_W{1'b0}};
      pix_rd_row_q <= {ROW_W{1'b0}};
      colour_q     <= 6'd0;
      m_clk_q      <= 1'b0;
    end else begin
      active_q     <= active_d;
      k_q          <= k_d;
      pix_rd_col_q <= pix_rd_col_d;
      pix_rd_row_q <= pix_rd_row_d;
      colour_q     <= colour_d;
      m_clk_q      <= m_clk_d;
    end
  end

  assign pix_rd_col = pix_rd_col_q;
  assign pix_rd_row = pix_rd_row_q;
  assign colour     = colour_q;
  assign m_clk      = m_clk_q;
  assign last       = active_q && (k_q == K_LAST);

endmodule

// File: rtl/matrix_scan_driver.sv
// HUB75-style row scan driver: shifts one row of pixels, blanks, latches and
// displays it for ON_CYCLES clocks, then advances to the next row.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS_HALF = DEF_ROWS_HALF,
  parameter int ON_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [$clog2(COLS)-1:0]      pix_rd_col,
  output logic [$clog2(ROWS_HALF)-1:0] pix_rd_row,
  input  logic [5:0]                   pix_data,
  output logic                         r0,
  output logic                         g0,
  output logic                         b0,
  output logic                         r1,
  output logic                         g1,
  output logic                         b1,
  output logic                         m_clk,
  output logic                         m_lat,
  output logic                         m_oe_n,
  output logic [$clog2(ROWS_HALF)-1:0] m_addr,
  output logic                         frame_done
);

  localparam int ROW_W = $clog2(ROWS_HALF);
  localparam int CNT_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ON_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = {ROW_W{1'b1}};

  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_lat_q, m_lat_d;
  logic             m_oe_n_q, m_oe_n_d;
  logic [ROW_W-1:0] m_addr_q, m_addr_d;
  logic             frame_done_q, frame_done_d;
  logic             shift_start_s;
  logic             shift_last_s;
  logic [5:0]       colour_s;

  // Row sequencing FSM next-state and output decode
  always_comb begin
    state_d       = state_q;
    r_d           = r_q;
    cnt_d         = cnt_q;
    m_addr_d      = m_addr_q;
    frame_done_d  = 1'b0;
    shift_start_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d       = ST_SHIFT;
          shift_start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_last_s) begin
          state_d  = ST_BLANK;
          m_addr_d = r_q;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_BLANK: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = ST_DISPLAY;
        cnt_d   = {CNT_W{1'b0}};
      end
      ST_DISPLAY: begin
        if (cnt_q == CNT_LAST) begin
          r_d          = r_q + ROW_W'(1);
          frame_done_d = (r_q == ROW_LAST);
          if (en) begin
            state_d       = ST_SHIFT;
            shift_start_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    m_lat_d  = (state_d == ST_LATCH);
    m_oe_n_d = (state_d != ST_DISPLAY);
  end

  // FSM state and registered panel control outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      r_q          <= {ROW_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      m_lat_q      <= 1'b0;
      m_oe_n_q     <= 1'b1;
      m_addr_q     <= {ROW_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      cnt_q        <= cnt_d;
      m_lat_q      <= m_lat_d;
      m_oe_n_q     <= m_oe_n_d;
      m_addr_q     <= m_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  matrix_shift_out #(
    .COLS      (COLS),
    .ROWS_HALF (ROWS_HALF)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .start      (shift_start_s),
    .row        (r_d),
    .pix_data   (pix_data),
    .pix_rd_col (pix_rd_col),
    .pix_rd_row (pix_rd_row),
    .colour     (colour_s),
    .m_clk      (m_clk),
    .last       (shift_last_s)
  );

  assign r0         = colour_s[PIX_R0];
  assign g0         = colour_s[PIX_G0];
  assign b0         = colour_s[PIX_B0];
  assign r1         = colour_s[PIX_R1];
  assign g1         = colour_s[PIX_G1];
  assign b1         = colour_s[PIX_B1];
  assign m_lat      = m_lat_q;
  assign m_oe_n     = m_oe_n_q;
  assign m_addr     = m_addr_q;
  assign frame_done = frame_done_q;

endmodule
